// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
// Contents: state_t (BOOT, RUN, FAULT), NOP instruction word, default reset vector.
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: three free-running 32-bit event counters for the fetch stage.
// Ports: clk, reset (async, active-high), fetch_inc/stall_inc/flush_inc (per-cycle
// event strobes), fetch_count/stall_count/flush_count (wrap modulo 2^32).
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            fetch_count <= fetch_count + {31'd0, fetch_inc};
            stall_count <= stall_count + {31'd0, stall_inc};
            flush_count <= flush_count + {31'd0, flush_inc};
        end
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC owner and IF/ID loader for the five-stage MIPS pipeline.
// Ports: clk, reset (async, active-high); Stall, Flush, Redirect, RedirectTarget
// (hazard/branch requests, priority Redirect > Flush > Stall); IMemAddress /
// IMemInstruction (combinational instruction memory); IF_ID_Instruction, IF_ID_PC,
// IF_ID_PCPlus4, IF_ID_Valid (IF/ID register); MisalignFault (sticky trap).
// Optional: macro FETCH_PERF_CNT_EN adds FetchCount, StallCount, FlushCount outputs.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        MisalignFault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);
    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] instr_next, ifpc_next, ifp4_next;
    logic        valid_next, fault_next;
    logic        load, bubble;

    // PC register drives memory directly: no input-to-address combinational path.
    assign IMemAddress = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= BOOT;
            pc                <= RESET_VECTOR;
            IF_ID_Instruction <= NOP;
            IF_ID_PC          <= '0;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
            MisalignFault     <= 1'b0;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            IF_ID_Instruction <= instr_next;
            IF_ID_PC          <= ifpc_next;
            IF_ID_PCPlus4     <= ifp4_next;
            IF_ID_Valid       <= valid_next;
            MisalignFault     <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        fault_next = MisalignFault;
        load       = 1'b0;
        bubble     = 1'b0;
        if (state == BOOT) begin
            state_next = RUN;
        end else if (state == FAULT) begin
            bubble = 1'b1;
        end else if (Redirect) begin
            bubble = 1'b1;
            if (RedirectTarget[1:0] != 2'b00) begin
                fault_next = 1'b1;
                state_next = FAULT;
            end else begin
                pc_next = RedirectTarget;
            end
        end else if (Flush) begin
            bubble = 1'b1;
        end else if (!Stall) begin
            load    = 1'b1;
            pc_next = pc + 32'd4;
        end
        // Neither load nor bubble means hold, which covers Stall and BOOT.
        instr_next = bubble ? NOP  : load ? IMemInstruction : IF_ID_Instruction;
        ifpc_next  = bubble ? '0   : load ? pc              : IF_ID_PC;
        ifp4_next  = bubble ? '0   : load ? pc + 32'd4      : IF_ID_PCPlus4;
        valid_next = bubble ? 1'b0 : load ? 1'b1            : IF_ID_Valid;
    end

`ifdef FETCH_PERF_CNT_EN
    logic in_run;
    assign in_run = (state == RUN);

    fetch_perf_counters u_perf (
        .clk         (clk),
        .reset       (reset),
        .fetch_inc   (load),
        .stall_inc   (in_run && Stall && !Redirect && !Flush),
        .flush_inc   (in_run && (Flush || Redirect)),
        .fetch_count (FetchCount),
        .stall_count (StallCount),
        .flush_count (FlushCount)
    );
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller (table vectors,
// hand-written corner sequences, randomized run against a behavioural model).
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0, Flush = 1'b0, Redirect = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic [31:0] IMemAddress, IMemInstruction;
    logic [31:0] IF_ID_Instruction, IF_ID_PC, IF_ID_PCPlus4;
    logic        IF_ID_Valid, MisalignFault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, StallCount, FlushCount;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] i);
        return (i == 8'd0) ? 32'h24020002 : (i == 8'd1) ? 32'h24080000 : {16'hA5A5, 8'h00, i};
    endfunction

    assign IMemInstruction = word(IMemAddress[9:2]);

    fetch_controller dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .Redirect          (Redirect),
        .RedirectTarget    (RedirectTarget),
        .IMemAddress       (IMemAddress),
        .IMemInstruction   (IMemInstruction),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .MisalignFault     (MisalignFault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount        (FetchCount),
        .StallCount        (StallCount),
        .FlushCount        (FlushCount)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic f, input logic r, input logic [31:0] t);
        Stall = s; Flush = f; Redirect = r; RedirectTarget = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"}, IMemAddress, 32'h0040_0000);
        chk({tag, "_instr"}, IF_ID_Instruction, 32'h0);
        chk({tag, "_pc"}, IF_ID_PC, 32'h0);
        chk({tag, "_pc4"}, IF_ID_PCPlus4, 32'h0);
        chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, 32'd0);
        chk({tag, "_fault"}, {31'd0, MisalignFault}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fetchcnt"}, FetchCount, 32'd0);
        chk({tag, "_stallcnt"}, StallCount, 32'd0);
        chk({tag, "_flushcnt"}, FlushCount, 32'd0);
`endif
    endtask

    // Behavioural model: what the fetch stage should hold, as plain variables.
    typedef struct {
        logic        boot, fault, v;
        logic [31:0] pc, ins, ipc, ip4, fc, sc, flc;
    } model_t;
    model_t m;

    task automatic m_reset();
        m.boot = 1'b1; m.fault = 1'b0; m.v = 1'b0;
        m.pc = 32'h0040_0000; m.ins = '0; m.ipc = '0; m.ip4 = '0;
        m.fc = '0; m.sc = '0; m.flc = '0;
    endtask

    task automatic m_kill();
        m.ins = '0; m.ipc = '0; m.ip4 = '0; m.v = 1'b0;
    endtask

    task automatic m_step(input logic s, input logic f, input logic r, input logic [31:0] t);
        if (m.boot) m.boot = 1'b0;
        else if (m.fault) m_kill();
        else if (r) begin
            m.flc++;
            m_kill();
            if (t % 4 != 0) m.fault = 1'b1;
            else m.pc = t;
        end else if (f) begin
            m.flc++;
            m_kill();
        end else if (s) m.sc++;
        else begin
            m.ins = word(m.pc[9:2]); m.ipc = m.pc; m.ip4 = m.pc + 4; m.v = 1'b1;
            m.pc = m.pc + 4; m.fc++;
        end
    endtask

    task automatic m_compare(input string tag);
        chk({tag, "_addr"}, IMemAddress, m.pc);
        chk({tag, "_instr"}, IF_ID_Instruction, m.ins);
        chk({tag, "_pc"}, IF_ID_PC, m.ipc);
        chk({tag, "_pc4"}, IF_ID_PCPlus4, m.ip4);
        chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, {31'd0, m.v});
        chk({tag, "_fault"}, {31'd0, MisalignFault}, {31'd0, m.fault});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fetchcnt"}, FetchCount, m.fc);
        chk({tag, "_stallcnt"}, StallCount, m.sc);
        chk({tag, "_flushcnt"}, FlushCount, m.flc);
`endif
    endtask

    typedef struct {
        logic        s, f, r;
        logic [31:0] tgt, addr;
        logic        v;
        logic [31:0] ipc, ins;
    } vec_t;
    vec_t tbl[16];

    initial begin
        // Row 0 is the BOOT edge: the redirect there must be ignored.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h00400200, 32'h00400000, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400004, 1'b1, 32'h00400000, 32'h24020002};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400008, 1'b1, 32'h00400004, 32'h24080000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0040000C, 1'b1, 32'h00400008, 32'hA5A50002};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400010, 1'b1, 32'h0040000C, 32'hA5A50003};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400014, 1'b1, 32'h00400010, 32'hA5A50004};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h00400014, 1'b1, 32'h00400010, 32'hA5A50004};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h00400014, 1'b1, 32'h00400010, 32'hA5A50004};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h00400014, 1'b1, 32'h00400010, 32'hA5A50004};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400018, 1'b1, 32'h00400014, 32'hA5A50005};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h0040012C, 32'h0040012C, 1'b0, 32'h0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400130, 1'b1, 32'h0040012C, 32'hA5A5004B};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h00400130, 1'b0, 32'h0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400134, 1'b1, 32'h00400130, 32'hA5A5004C};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h00400100, 32'h00400100, 1'b0, 32'h0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400104, 1'b1, 32'h00400100, 32'hA5A50040};

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_held");
        reset = 1'b0;
        #1;
        check_reset_values("boot");

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].s, tbl[i].f, tbl[i].r, tbl[i].tgt);
            chk($sformatf("tbl%0d_addr", i), IMemAddress, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, IF_ID_Valid}, {31'd0, tbl[i].v});
            chk($sformatf("tbl%0d_pc", i), IF_ID_PC, tbl[i].ipc);
            chk($sformatf("tbl%0d_pc4", i), IF_ID_PCPlus4, tbl[i].v ? tbl[i].ipc + 32'd4 : 32'h0);
            chk($sformatf("tbl%0d_instr", i), IF_ID_Instruction, tbl[i].ins);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("tbl_fetchcnt", FetchCount, 32'd9);
        chk("tbl_stallcnt", StallCount, 32'd3);
        chk("tbl_flushcnt", FlushCount, 32'd3);
`endif

        // Misaligned redirect traps and freezes the PC until reset.
        tick(1'b0, 1'b0, 1'b1, 32'h00400102);
        chk("mis_fault", {31'd0, MisalignFault}, 32'd1);
        chk("mis_addr", IMemAddress, 32'h00400104);
        chk("mis_valid", {31'd0, IF_ID_Valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
            chk($sformatf("fault%0d_addr", i), IMemAddress, 32'h00400104);
            chk($sformatf("fault%0d_valid", i), {31'd0, IF_ID_Valid}, 32'd0);
            chk($sformatf("fault%0d_flag", i), {31'd0, MisalignFault}, 32'd1);
        end

        // Reset takes effect without waiting for a clock edge.
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h00400040);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetchcnt", FetchCount, 32'd5);
        chk("perf_stallcnt", StallCount, 32'd2);
        chk("perf_flushcnt", FlushCount, 32'd1);
`endif
        chk("perf_addr", IMemAddress, 32'h00400040);

        // PC+4 wraps from the top of the address space without faulting.
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", IMemAddress, 32'h0);
        chk("wrap_pc", IF_ID_PC, 32'hFFFF_FFFC);
        chk("wrap_pc4", IF_ID_PCPlus4, 32'h0);
        chk("wrap_fault", {31'd0, MisalignFault}, 32'd0);

        // Randomized run against the behavioural model.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_reset();
        m_compare("rnd_start");
        for (int i = 0; i < 1500; i++) begin
            logic s, f, r;
            logic [31:0] t;
            if ($urandom_range(59) == 0) begin
                reset = 1'b1;
                #1;
                m_reset();
                m_compare("rnd_reset");
                reset = 1'b0;
            end
            s = ($urandom_range(3) == 0);
            f = ($urandom_range(7) == 0);
            r = ($urandom_range(5) == 0);
            t = {22'h00_1001, 8'($urandom), 2'b00};
            if ($urandom_range(29) == 0) t[1:0] = 2'($urandom_range(3, 1));
            else if ($urandom_range(49) == 0) t = 32'hFFFF_FFFC;
            tick(s, f, r, t);
            m_step(s, f, r, t);
            m_compare("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
